// File: rtl/stage_memory_if.sv
// Bundle between the memory stage and its neighbours: the execute-side
// input handshake, the data-memory bus and the writeback-side output.
//
// Handshake rules (both in_* and out_* channels): a transfer happens on a
// rising edge where valid && ready are both high; the producer holds valid
// and its payload stable until that edge. dmem_req is likewise held with
// stable fields until the edge on which dmem_ready is high.
interface stage_memory_if;
    // execute -> stage
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_res;
    logic [31:0] in_rs2_data;
    // stage <-> data memory
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    // stage -> writeback
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [31:0] out_alu_res;
    logic [31:0] out_dmem_out;
    logic        out_misaligned;
    logic        out_bus_err;
    // FSM observation: 1 while a memory access is outstanding
    logic        dbg_state;

    // Environment side: execute, memory and writeback
    modport master (
        output in_valid, in_pc, in_opcode, in_funct3, in_alu_res, in_rs2_data,
        output dmem_ready, dmem_rdata, out_ready,
        input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  out_valid, out_pc, out_opcode, out_funct3, out_alu_res,
        input  out_dmem_out, out_misaligned, out_bus_err, dbg_state
    );

    // Memory stage side
    modport slave (
        input  in_valid, in_pc, in_opcode, in_funct3, in_alu_res, in_rs2_data,
        input  dmem_ready, dmem_rdata, out_ready,
        output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output out_valid, out_pc, out_opcode, out_funct3, out_alu_res,
        output out_dmem_out, out_misaligned, out_bus_err, dbg_state
    );
endinterface

// File: rtl/stage_memory.sv
// RV32I memory stage: issues word-aligned loads/stores with byte strobes,
// returns load data shifted down to bit 0, and passes other instructions
// through a single output register.
module stage_memory #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic          clk,
    input logic          rst,
    stage_memory_if.slave bus
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int         CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]    off_q, off_d;
    logic          is_load_q, is_load_d;
    logic          dmem_req_q, dmem_req_d;
    logic          dmem_we_q, dmem_we_d;
    logic [31:0]   dmem_addr_q, dmem_addr_d;
    logic [31:0]   dmem_wdata_q, dmem_wdata_d;
    logic [3:0]    dmem_wstrb_q, dmem_wstrb_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_pc_q, out_pc_d;
    logic [6:0]    out_opcode_q, out_opcode_d;
    logic [2:0]    out_funct3_q, out_funct3_d;
    logic [31:0]   out_alu_res_q, out_alu_res_d;
    logic [31:0]   out_dmem_out_q, out_dmem_out_d;
    logic          out_mis_q, out_mis_d;
    logic          out_err_q, out_err_d;

    logic        in_fire;
    logic        is_load, is_store, is_byte, is_half, misaligned;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic        timeout_hit;

    assign bus.in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign in_fire      = bus.in_valid && bus.in_ready;

    // funct3[1:0]: 00 byte, 01 half, anything else is handled as a word
    assign is_load    = (bus.in_opcode == OP_LOAD);
    assign is_store   = (bus.in_opcode == OP_STORE);
    assign is_byte    = (bus.in_funct3[1:0] == 2'b00);
    assign is_half    = (bus.in_funct3[1:0] == 2'b01);
    assign misaligned = is_half ? bus.in_alu_res[0]
                      : (!is_byte && (bus.in_alu_res[1:0] != 2'b00));

    // The final wait cycle is the one where the counter sits at TIMEOUT-1
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Store lane encoding: data replicated into every lane, strobes pick the lanes
    always_comb begin
        st_strb = 4'b1111;
        st_data = bus.in_rs2_data;
        if (is_byte) begin
            st_strb = 4'b0001 << bus.in_alu_res[1:0];
            st_data = {4{bus.in_rs2_data[7:0]}};
        end else if (is_half) begin
            st_strb = 4'b0011 << {bus.in_alu_res[1], 1'b0};
            st_data = {2{bus.in_rs2_data[15:0]}};
        end
    end

    // Next-state logic for the FSM, the bus request and the output register
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        off_d          = off_q;
        is_load_d      = is_load_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        dmem_wstrb_d   = dmem_wstrb_q;
        out_valid_d    = out_valid_q;
        out_pc_d       = out_pc_q;
        out_opcode_d   = out_opcode_q;
        out_funct3_d   = out_funct3_q;
        out_alu_res_d  = out_alu_res_q;
        out_dmem_out_d = out_dmem_out_q;
        out_mis_d      = out_mis_q;
        out_err_d      = out_err_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    out_pc_d       = bus.in_pc;
                    out_opcode_d   = bus.in_opcode;
                    out_funct3_d   = bus.in_funct3;
                    out_alu_res_d  = bus.in_alu_res;
                    out_dmem_out_d = 32'd0;
                    out_mis_d      = 1'b0;
                    out_err_d      = 1'b0;
                    if (!(is_load || is_store)) begin
                        out_valid_d = 1'b1;
                    end else if (misaligned) begin
                        out_valid_d = 1'b1;
                        out_mis_d   = 1'b1;
                    end else begin
                        state_d      = S_ACCESS;
                        wait_cnt_d   = '0;
                        off_d        = bus.in_alu_res[1:0];
                        is_load_d    = is_load;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = is_store;
                        dmem_addr_d  = {bus.in_alu_res[31:2], 2'b00};
                        dmem_wdata_d = is_store ? st_data : 32'd0;
                        dmem_wstrb_d = is_store ? st_strb : 4'b1111;
                    end
                end
            end
            S_ACCESS: begin
                if (bus.dmem_ready) begin
                    dmem_req_d     = 1'b0;
                    out_valid_d    = 1'b1;
                    out_dmem_out_d = is_load_q ? (bus.dmem_rdata >> {off_q, 3'b000}) : 32'd0;
                    state_d        = S_IDLE;
                end else if (timeout_hit) begin
                    dmem_req_d     = 1'b0;
                    out_valid_d    = 1'b1;
                    out_err_d      = 1'b1;
                    out_dmem_out_d = 32'd0;
                    state_d        = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any outstanding request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wait_cnt_q     <= '0;
            off_q          <= 2'd0;
            is_load_q      <= 1'b0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= 32'd0;
            dmem_wdata_q   <= 32'd0;
            dmem_wstrb_q   <= 4'd0;
            out_valid_q    <= 1'b0;
            out_pc_q       <= 32'd0;
            out_opcode_q   <= 7'd0;
            out_funct3_q   <= 3'd0;
            out_alu_res_q  <= 32'd0;
            out_dmem_out_q <= 32'd0;
            out_mis_q      <= 1'b0;
            out_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            off_q          <= off_d;
            is_load_q      <= is_load_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            dmem_wstrb_q   <= dmem_wstrb_d;
            out_valid_q    <= out_valid_d;
            out_pc_q       <= out_pc_d;
            out_opcode_q   <= out_opcode_d;
            out_funct3_q   <= out_funct3_d;
            out_alu_res_q  <= out_alu_res_d;
            out_dmem_out_q <= out_dmem_out_d;
            out_mis_q      <= out_mis_d;
            out_err_q      <= out_err_d;
        end
    end

    assign bus.dmem_req       = dmem_req_q;
    assign bus.dmem_we        = dmem_we_q;
    assign bus.dmem_addr      = dmem_addr_q;
    assign bus.dmem_wdata     = dmem_wdata_q;
    assign bus.dmem_wstrb     = dmem_wstrb_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_opcode     = out_opcode_q;
    assign bus.out_funct3     = out_funct3_q;
    assign bus.out_alu_res    = out_alu_res_q;
    assign bus.out_dmem_out   = out_dmem_out_q;
    assign bus.out_misaligned = out_mis_q;
    assign bus.out_bus_err    = out_err_q;
    assign bus.dbg_state      = (state_q == S_ACCESS);
endmodule

// File: doc/stage_memory.md
# stage_memory

Pipeline memory stage of the RV32I core, between execute and writeback. Takes one execute result per valid/ready handshake and issues aligned word accesses with byte strobes for loads and stores over a ready-based data-memory bus. Returns load data right-shifted so the addressed byte or halfword sits at bit 0; writeback then sign- or zero-extends it. Non-memory instructions pass through one register stage unchanged.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles a memory request waits for `dmem_ready` before abort; 0 disables the timeout.

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  execute presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  32  instruction PC
- in_opcode  in  7  instruction opcode
- in_funct3  in  3  instruction funct3
- in_alu_res  in  32  ALU result; effective address for LOAD/STORE
- in_rs2_data  in  32  store data
- dmem_req  out  1  memory request, held until accepted
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte strobes
- dmem_ready  in  1  request completes this cycle
- dmem_rdata  in  32  read word, valid when `dmem_ready`
- out_valid  out  1  result to writeback is valid
- out_ready  in  1  writeback consumes
- out_pc, out_opcode, out_funct3, out_alu_res  out  32/7/3/32  registered copies of inputs
- out_dmem_out  out  32  shifted load data; 0 for non-loads
- out_misaligned  out  1  access rejected for alignment
- out_bus_err  out  1  access aborted by timeout

## Operation
- Opcodes: LOAD = 7'b0000011, STORE = 7'b0100011; anything else is a pass-through.
- States: IDLE, ACCESS.
- `in_ready = (state == IDLE) && (!out_valid || out_ready)`.
- Accept in IDLE, non-memory op: load the output register, `out_dmem_out = 0`, flags 0, `out_valid = 1`; stay in IDLE.
- Accept in IDLE, memory op:
  - Misaligned cases: LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] ≠ 0.
  - If misaligned: no request; output register loads with `out_misaligned = 1`, `out_dmem_out = 0`; stay in IDLE.
  - Otherwise: latch the request fields and go to ACCESS.
- ACCESS: `dmem_req = 1` with stable addr/we/wdata/wstrb. The wait counter starts at 0 and increments each cycle that `dmem_ready` is low.
  - `dmem_ready = 1`: capture `out_dmem_out = dmem_rdata >> (8*addr[1:0])` for loads (0 for stores), set `out_valid`, go to IDLE.
  - Counter reaches TIMEOUT_CYCLES (nonzero) with `dmem_ready` low: drop `dmem_req`, set `out_valid` with `out_bus_err = 1`, `out_dmem_out = 0`, go to IDLE.
- Store encoding:
  - SB: strobe 4'b0001 << addr[1:0], data {4{rs2[7:0]}}.
  - SH: strobe 4'b0011 << {addr[1],1'b0}, data {2{rs2[15:0]}}.
  - SW: strobe 4'b1111, data rs2.
- Loads: `dmem_we = 0`, strobe 4'b1111.
- Unknown funct3 on LOAD/STORE: treat as word.
- Output register holds while `out_valid && !out_ready`. `out_valid` clears on `out_ready` unless a new result loads the same cycle.

## Timing
- Reset (async, immediate): state IDLE, `dmem_req = 0`, `out_valid = 0`, every other output register 0, wait counter 0.
- Non-memory and misaligned: accepted in cycle N, `out_valid` in N+1.
- Memory: accepted in N, `dmem_req` from N+1. If `dmem_ready` arrives in cycle M ≥ N+1, `out_valid` is in M+1 and `in_ready` can be high in M+1.
- `in_ready` is low throughout ACCESS. Back-to-back pass-through runs at one per cycle while `out_ready = 1`.
- `dmem_req` never deasserts before `dmem_ready` except on timeout or reset.
- Reset during ACCESS abandons the request; the memory must tolerate a dropped request.
- `dmem_ready` while not in ACCESS is ignored.

## Test plan
- Reset with `in_valid = 1`: every output 0 and `in_ready = 1` after release. Then ADD result 0x1234 at pc 0x100: `out_valid` next cycle, `out_alu_res = 0x1234`, `out_dmem_out = 0`.
- LB at addr 0x1003, `dmem_rdata = 0xAABBCCDD`, `dmem_ready` 3 cycles after req:
  - `dmem_addr = 0x1000`, `dmem_we = 0`.
  - `in_ready` low during the wait.
  - `out_dmem_out = 0x000000AA` one cycle after ready.
- SH at addr 0x2002 with `rs2 = 0x0000BEEF`: `dmem_wstrb = 4'b1100`, `dmem_wdata = 0xBEEFBEEF`, `dmem_we = 1`. SB at 0x2001 with `rs2 = 0x12`: strobe 4'b0010, data 0x12121212.
- LW at 0x3002: no `dmem_req`; `out_misaligned = 1` the next cycle. SH at 0x3001 gives the same result.
- TIMEOUT_CYCLES = 4 and `dmem_ready` held low: `dmem_req` drops after 4 waiting cycles, `out_bus_err = 1`, and the next instruction is accepted.
- `out_ready = 0` for 5 cycles with a completed load pending: outputs stable and `in_ready` low. Assert `rst` mid-ACCESS: `dmem_req` and `out_valid` go to 0 immediately.
